// File: rtl/branch_cmp.sv
// branch_cmp: serial 64-bit compare for RISC-V conditional branches.
//
// Computes s1 - s2 as s1 + ~s2 + 1, CHUNK bits per clock, least-significant
// chunk first, and derives zero/negative/overflow/carry plus the branch
// decision selected by funct3.  A full operation takes 64/CHUNK cycles.
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   rst      : synchronous active-high reset
//   start    : request, accepted only in IDLE or DONE
//   s1, s2   : 64-bit minuend / subtrahend, latched on an accepted start
//   funct3   : branch condition code, latched on an accepted start
//   busy     : high while an operation is in progress (RUN)
//   done     : one-cycle pulse, outputs below are valid
//   taken    : branch decision
//   zero, negative, overflow, carry : flags of s1 - s2
//   illegal  : latched funct3 was 010 or 011

module branch_cmp #(
    parameter int CHUNK = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] s1,
    input  logic [63:0] s2,
    input  logic [2:0]  funct3,
    output logic        busy,
    output logic        done,
    output logic        taken,
    output logic        zero,
    output logic        negative,
    output logic        overflow,
    output logic        carry,
    output logic        illegal
);

    localparam int         N    = 64 / CHUNK;
    localparam logic [3:0] LAST = 4'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]   state;
    logic [63:0]  a;
    logic [63:0]  b;
    logic [2:0]   f3;
    logic         sign_a;
    logic         sign_b;
    logic [3:0]   idx;
    logic         cin;
    logic         zacc;

    logic [CHUNK:0] sum;
    logic           chunk_zero;
    logic           fin_zero;
    logic           fin_neg;
    logic           fin_ovf;
    logic           fin_carry;
    logic           fin_taken;
    logic           fin_illegal;

    // Operands are shifted right each cycle, so the active chunk always sits
    // in the low CHUNK bits.  The operand signs are kept separately because
    // the overflow rule needs the original bit 63 of both operands.
    always_comb begin
        sum        = {1'b0, a[CHUNK-1:0]} + {1'b0, ~b[CHUNK-1:0]} + {{CHUNK{1'b0}}, cin};
        chunk_zero = (sum[CHUNK-1:0] == '0);

        // Only meaningful while processing the last chunk, where sum holds
        // result bits 63..64-CHUNK and the final carry-out.
        fin_zero    = zacc & chunk_zero;
        fin_neg     = sum[CHUNK-1];
        fin_ovf     = (sign_a != sign_b) && (sum[CHUNK-1] != sign_a);
        fin_carry   = sum[CHUNK];
        fin_illegal = (f3[2:1] == 2'b01);

        fin_taken = 1'b0;
        case (f3)
            3'b000:  fin_taken = fin_zero;
            3'b001:  fin_taken = ~fin_zero;
            3'b100:  fin_taken = fin_neg ^ fin_ovf;
            3'b101:  fin_taken = ~(fin_neg ^ fin_ovf);
            3'b110:  fin_taken = ~fin_carry;
            3'b111:  fin_taken = fin_carry;
            default: fin_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a        <= '0;
            b        <= '0;
            f3       <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            idx      <= '0;
            cin      <= 1'b0;
            zacc     <= 1'b0;
            taken    <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
            overflow <= 1'b0;
            carry    <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a      <= s1;
                        b      <= s2;
                        f3     <= funct3;
                        sign_a <= s1[63];
                        sign_b <= s2[63];
                        idx    <= '0;
                        cin    <= 1'b1;
                        zacc   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    a    <= a >> CHUNK;
                    b    <= b >> CHUNK;
                    cin  <= sum[CHUNK];
                    zacc <= zacc & chunk_zero;
                    idx  <= idx + 4'd1;
                    if (idx == LAST) begin
                        // Result registers change only here, on entry to DONE.
                        state    <= DONE;
                        taken    <= fin_taken & ~fin_illegal;
                        zero     <= fin_zero;
                        negative <= fin_neg;
                        overflow <= fin_ovf;
                        carry    <= fin_carry;
                        illegal  <= fin_illegal;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
